// File: rtl/fp16_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fp16_pkg
// Purpose : Shared constants and types for the bfloat16 reduction controller.
//           Adder latency, the bfloat16 zero pattern, the controller's
//           state encoding and the partial-buffer depth.
// Revision: 1.0 - initial release
// ============================================================================
package fp16_pkg;

  typedef logic [15:0] bf16_t;

  localparam int    ADD_LAT   = 4;
  localparam bf16_t BF16_ZERO = 16'h0000;

  // The partial buffer never needs more slots than there can be adds in flight.
  localparam int BUF_DEPTH = ADD_LAT;
  localparam int CNT_W     = $clog2(ADD_LAT + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] REDUCE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/fp16_partial_buf.sv
`default_nettype none
// ============================================================================
// Module  : fp16_partial_buf
// Purpose : 4 x 16 FIFO holding partial sums that came back from the adder
//           while no operand slot was free. One push per cycle; pop of 0, 1
//           or 2 entries per cycle. Head and the entry behind it are both
//           visible so a pair can be popped in one cycle.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           push_i          - write push_data_i at the tail
//           push_data_i     - partial sum to store
//           pop_cnt_i       - number of entries to remove from the head (0..2)
//           head_o, next_o  - oldest and second-oldest entries
//           count_o         - current occupancy (0..4)
// Revision: 1.0 - initial release
// ============================================================================
module fp16_partial_buf
  import fp16_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [15:0]      push_data_i,
  input  logic [1:0]       pop_cnt_i,
  output logic [15:0]      head_o,
  output logic [15:0]      next_o,
  output logic [CNT_W-1:0] count_o
);

  logic [15:0]      mem_q [BUF_DEPTH];
  logic [1:0]       rd_ptr_q;
  logic [1:0]       wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      count_q  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= BF16_ZERO;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      rd_ptr_q <= rd_ptr_q + pop_cnt_i;
      count_q  <= count_q + CNT_W'(push_i) - CNT_W'(pop_cnt_i);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[rd_ptr_q + 2'd1];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/fp16_sum_res_pipe.sv
`default_nettype none
// ============================================================================
// Module  : fp16_sum_res_pipe
// Purpose : 4-stage pipelined bfloat16 adder/subtractor.
//           Stage 1 aligns the smaller operand, stage 2 adds/subtracts the
//           mantissas, stage 3 normalises and rounds to nearest-even, stage 4
//           registers the result. Subnormal inputs and results flush to +0;
//           exponent overflow produces a signed infinity.
// Ports   : clk, rst  - clock, synchronous active-high reset
//           en        - issue x1 op x2 this cycle
//           add_sub   - 0: x1 + x2, 1: x1 - x2
//           x1, x2    - bfloat16 operands
//           y, ready  - result and its valid flag, four cycles after en
// Revision: 1.0 - initial release
// ============================================================================
module fp16_sum_res_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        add_sub,
  input  logic [15:0] x1,
  input  logic [15:0] x2,
  output logic [15:0] y,
  output logic        ready
);

  // ---------------- stage 1: swap and align ----------------
  logic        w_a_big;
  logic        w_sb;
  logic [7:0]  w_ma, w_mb, w_big_m, w_sml_m;
  logic [7:0]  w_big_e, w_sml_e, w_d;
  logic        w_big_s, w_sml_s;
  logic [23:0] w_shift;
  logic [10:0] w_sml_al;

  always_comb begin
    w_sb    = x2[15] ^ add_sub;
    w_ma    = (x1[14:7] != 8'd0) ? {1'b1, x1[6:0]} : 8'h00;
    w_mb    = (x2[14:7] != 8'd0) ? {1'b1, x2[6:0]} : 8'h00;
    w_a_big = (x1[14:0] >= x2[14:0]);
    w_big_s = w_a_big ? x1[15]   : w_sb;
    w_sml_s = w_a_big ? w_sb     : x1[15];
    w_big_e = w_a_big ? x1[14:7] : x2[14:7];
    w_sml_e = w_a_big ? x2[14:7] : x1[14:7];
    w_big_m = w_a_big ? w_ma     : w_mb;
    w_sml_m = w_a_big ? w_mb     : w_ma;
    w_d     = w_big_e - w_sml_e;
    w_shift = {w_sml_m, 16'h0000} >> w_d;
    // Keep guard and round bits, fold everything below into sticky.
    w_sml_al = {w_shift[23:14], |w_shift[13:0]};
  end

  logic        s1_v_q, s1_s_q, s1_sub_q;
  logic [7:0]  s1_e_q;
  logic [10:0] s1_ma_q, s1_mb_q;

  // ---------------- stage 2: mantissa add ----------------
  logic        s2_v_q, s2_s_q;
  logic [7:0]  s2_e_q;
  logic [11:0] s2_sum_q;

  // ---------------- stage 3: normalise and round ----------------
  logic [3:0]  w_lz;
  logic [10:0] w_n;
  logic [9:0]  w_en, w_eo;
  logic        w_zero, w_rup;
  logic [8:0]  w_m9;
  logic [15:0] w_res;

  always_comb begin
    w_lz = 4'd0;
    for (int i = 0; i < 11; i++) begin
      if (s2_sum_q[i]) w_lz = 4'(10 - i);
    end
    if (s2_sum_q[11]) begin
      w_n    = {s2_sum_q[11:2], s2_sum_q[1] | s2_sum_q[0]};
      w_en   = {2'b00, s2_e_q} + 10'd1;
      w_zero = 1'b0;
    end else begin
      w_n    = s2_sum_q[10:0] << w_lz;
      w_en   = {2'b00, s2_e_q} - {6'd0, w_lz};
      w_zero = (s2_sum_q == 12'd0) || ({2'b00, s2_e_q} <= {6'd0, w_lz});
    end
    w_rup = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
    w_m9  = {1'b0, w_n[10:3]} + {8'd0, w_rup};
    w_eo  = w_m9[8] ? (w_en + 10'd1) : w_en;
    if (w_zero)
      w_res = 16'h0000;
    else if (w_eo >= 10'd255)
      w_res = {s2_s_q, 8'hFF, 7'h00};
    else
      w_res = {s2_s_q, w_eo[7:0], (w_m9[8] ? 7'h00 : w_m9[6:0])};
  end

  logic        s3_v_q, s4_v_q;
  logic [15:0] s3_y_q, s4_y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_s_q   <= 1'b0;
      s1_sub_q <= 1'b0;
      s1_e_q   <= 8'd0;
      s1_ma_q  <= 11'd0;
      s1_mb_q  <= 11'd0;
      s2_v_q   <= 1'b0;
      s2_s_q   <= 1'b0;
      s2_e_q   <= 8'd0;
      s2_sum_q <= 12'd0;
      s3_v_q   <= 1'b0;
      s3_y_q   <= 16'h0000;
      s4_v_q   <= 1'b0;
      s4_y_q   <= 16'h0000;
    end else begin
      s1_v_q   <= en;
      s1_s_q   <= w_big_s;
      s1_sub_q <= w_big_s ^ w_sml_s;
      s1_e_q   <= w_big_e;
      s1_ma_q  <= {w_big_m, 3'b000};
      s1_mb_q  <= w_sml_al;
      s2_v_q   <= s1_v_q;
      s2_s_q   <= s1_s_q;
      s2_e_q   <= s1_e_q;
      s2_sum_q <= s1_sub_q ? ({1'b0, s1_ma_q} - {1'b0, s1_mb_q})
                           : ({1'b0, s1_ma_q} + {1'b0, s1_mb_q});
      s3_v_q   <= s2_v_q;
      s3_y_q   <= w_res;
      s4_v_q   <= s3_v_q;
      s4_y_q   <= s3_y_q;
    end
  end

  assign y     = s4_y_q;
  assign ready = s4_v_q;

endmodule
`default_nettype wire

// File: rtl/fp16_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fp16_accum_ctrl
// Purpose : Streaming bfloat16 vector-sum controller. Keeps up to four
//           partial sums circulating through one 4-cycle adder plus a small
//           hold buffer, then folds the partials into a single result.
// Ports   : clk, rst     - clock, synchronous active-high reset (adder too)
//           start_i      - begin a reduction (only looked at in IDLE)
//           len_i        - element count, captured with start_i
//           in_data_i    - bfloat16 element
//           in_valid_i   - element valid
//           in_ready_o   - element accepted when in_valid_i is also high
//           sum_o        - final sum, held until the next result
//           sum_valid_o  - one-cycle pulse when sum_o updates
//           busy_o       - high in every state except IDLE
// Revision: 1.0 - initial release
// ============================================================================
module fp16_accum_ctrl
  import fp16_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [15:0]      in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [15:0]      sum_o,
  output logic             sum_valid_o,
  output logic             busy_o
);

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] infl_q, infl_d;
  logic [15:0]      sum_q, sum_d;
  logic             sum_valid_q, sum_valid_d;

  logic             w_ret;
  logic [15:0]      w_y;
  logic             w_issue;
  logic [15:0]      w_x1, w_x2;
  logic             w_push;
  logic [1:0]       w_pop_cnt;
  logic [15:0]      w_head, w_next;
  logic [CNT_W-1:0] w_held;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    acc_cnt_d   = acc_cnt_q;
    sum_d       = sum_q;
    sum_valid_d = 1'b0;
    w_issue     = 1'b0;
    w_x1        = BF16_ZERO;
    w_x2        = BF16_ZERO;
    w_push      = 1'b0;
    w_pop_cnt   = 2'd0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i == '0) begin
            sum_d       = BF16_ZERO;
            sum_valid_d = 1'b1;
          end else begin
            len_d     = len_i;
            acc_cnt_d = '0;
            state_d   = STREAM;
          end
        end
      end

      STREAM: begin
        if (in_valid_i) begin
          // Each element is paired with the freshest partial available;
          // a returning result is preferred so it never needs buffering.
          w_issue = 1'b1;
          w_x1    = in_data_i;
          if (w_ret) begin
            w_x2 = w_y;
          end else if (w_held != '0) begin
            w_x2      = w_head;
            w_pop_cnt = 2'd1;
          end
          acc_cnt_d = acc_cnt_q + LEN_W'(1);
          if (acc_cnt_d == len_q) state_d = REDUCE;
        end else if (w_ret) begin
          w_push = 1'b1;
        end
      end

      REDUCE: begin
        if (w_ret && (infl_q == CNT_W'(1)) && (w_held == '0)) begin
          // Last partial standing: this is the answer.
          sum_d       = w_y;
          sum_valid_d = 1'b1;
          state_d     = IDLE;
        end else if (w_ret && (w_held != '0)) begin
          w_issue   = 1'b1;
          w_x1      = w_y;
          w_x2      = w_head;
          w_pop_cnt = 2'd1;
        end else if (w_held >= CNT_W'(2)) begin
          w_issue   = 1'b1;
          w_x1      = w_next;
          w_x2      = w_head;
          w_pop_cnt = 2'd2;
        end else if (w_ret) begin
          w_push = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    infl_d = infl_q + CNT_W'(w_issue) - CNT_W'(w_ret);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      acc_cnt_q   <= '0;
      infl_q      <= '0;
      sum_q       <= BF16_ZERO;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      acc_cnt_q   <= acc_cnt_d;
      infl_q      <= infl_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  fp16_sum_res_pipe u_add (
    .clk     (clk),
    .rst     (rst),
    .en      (w_issue),
    .add_sub (1'b0),
    .x1      (w_x1),
    .x2      (w_x2),
    .y       (w_y),
    .ready   (w_ret)
  );

  fp16_partial_buf u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (w_push),
    .push_data_i (w_y),
    .pop_cnt_i   (w_pop_cnt),
    .head_o      (w_head),
    .next_o      (w_next),
    .count_o     (w_held)
  );

  assign in_ready_o  = (state_q == STREAM);
  assign busy_o      = (state_q != IDLE);
  assign sum_o       = sum_q;
  assign sum_valid_o = sum_valid_q;

endmodule
`default_nettype wire
